hash_msg_streamer: RTL
======================

// Module: hash_msg_streamer
// PURPOSE
// - Message source for the hash datapath: takes 32-bit words from a host over valid/ready.
// - Serialises them LSB byte first into the hash byte interface, with start and end-of-message strobes.
// - Captures the 32-bit digest the hash control returns and holds it for the host.
// - Sits between the host/bus wrapper and the hash core (control + operative part).
// PARAMETERS
// - LEN_W        64    width of msg_len byte counter; wraps mod 2^LEN_W, same as the core's length counter
// - TIMEOUT_CYC  1024  digest-wait watchdog limit in cycles (used only with HASH_STREAM_TIMEOUT_EN)
// PORTS
// - clock          in   1      single clock, rising edge
// - rstn           in   1      asynchronous active-low reset
// - in_start       in   1      1-cycle pulse: begin a new message (honoured in IDLE only)
// - in_word        in   32     message word; byte0 = in_word[7:0] is sent first
// - in_nbytes      in   3      valid bytes in the last word, 0..4; >4 treated as 4; ignored when in_last=0 (always 4)
// - in_last        in   1      word is the final one of the message
// - in_valid       in   1      host word valid
// - in_ready       out  1      streamer accepts word (LOAD state only)
// - h_start        out  1      1-cycle pulse to the hash core: reset digest and length
// - h_byte         out  8      message byte to the core
// - h_byte_valid   out  1      h_byte valid
// - h_byte_ready   in   1      core consumes h_byte this cycle
// - h_end          out  1      1-cycle pulse: message complete, run finalisation
// - h_digest_valid in   1      core digest valid (pulse or level)
// - h_digest       in   32     core digest
// - dig_valid      out  1      digest available to host
// - dig_out        out  32     held digest
// - dig_err        out  1      digest invalid (timeout); qualifies dig_valid
// - dig_ready      in   1      host consumes digest
// - msg_len        out  LEN_W  bytes sent in current/last message
// - busy           out  1      state != IDLE
// BEHAVIOUR
// - Reset (async, rstn=0): state IDLE; all outputs 0, including dig_out, msg_len, in_ready; word/byte regs 0.
// - FSM:
//   - IDLE -> START on in_start.
//   - START: h_start=1 for one cycle; msg_len<=0 -> LOAD.
//   - LOAD: in_ready=1. On in_valid: capture word; nb = in_last ? min(in_nbytes,4) : 4; capture last.
//     - nb>0: -> SEND, byte index 0.
//     - nb=0 and last: -> END.
//   - SEND: h_byte_valid=1, h_byte = word byte[idx]. On h_byte_ready: msg_len++, idx++.
//     - idx==nb-1 handshake: -> END if last, else LOAD.
//     - h_byte and h_byte_valid stay stable until the handshake.
//   - END: h_end=1 for one cycle -> WAIT.
//   - WAIT: on h_digest_valid: dig_out<=h_digest, dig_err<=0 -> DONE.
//   - DONE: dig_valid=1; on dig_ready -> IDLE. dig_out and msg_len hold until the next START.
// - in_start outside IDLE is ignored. h_digest_valid outside WAIT is ignored.
// - No combinational input->output paths. All strobes are registered state decodes.
// - Throughput: 1 byte/cycle with h_byte_ready=1. A 4-byte word costs LOAD + 4 SEND cycles.
// - Latency: in_start -> h_start is 1 cycle; last byte handshake -> h_end is 1 cycle.
// - Zero-length message (in_last, nb=0 on first word): no h_byte_valid; h_end still pulses; msg_len=0.
// - msg_len wraps to 0 past 2^LEN_W-1, no flag.
// - Reset mid-operation: immediate return to IDLE, all outputs 0, partial message discarded.
// CONFIGURATION
// - HASH_STREAM_TIMEOUT_EN defined:
//   - WAIT counts cycles; on reaching TIMEOUT_CYC without h_digest_valid: dig_out<=0, dig_err<=1 -> DONE.
//   - Counter clears on entering WAIT.
//   - h_digest_valid in the same cycle as expiry wins: normal digest, dig_err=0.
// - Undefined: WAIT waits indefinitely; dig_err tied 0; no counter logic.
// TESTING
// - Reset: after rstn release, all outputs 0, busy=0, in_ready=0; in_valid=1 alone does not change state.
// - "abc": start; word 0x00636261, nbytes=3, last.
//   - h_byte 0x61,0x62,0x63 on consecutive cycles, then h_end 1 cycle; msg_len=3.
//   - Core returns 0x1234ABCD -> dig_out=0x1234ABCD, dig_valid until dig_ready.
// - Backpressure: 2 words 0x44332211, 0x88776655 (last, nbytes=4); h_byte_ready toggled 1010.
//   - Bytes 0x11..0x88 in order, each held stable while unaccepted; msg_len=8.
// - Zero length: start; word with last, nbytes=0 -> no h_byte_valid, one h_end pulse, msg_len=0, digest captured.
// - Reset mid-SEND after 2 bytes: outputs 0, state IDLE. A following "abc" run sends 0x61 first; msg_len=3.
// - HASH_STREAM_TIMEOUT_EN, TIMEOUT_CYC=16: no h_digest_valid -> after 16 WAIT cycles, dig_valid=1, dig_err=1, dig_out=0.

Source files
------------

// File: rtl/hash_msg_streamer.sv
// Host-word to hash-byte streamer: serialises 32-bit words LSB byte first, frames them with
// start/end strobes and holds the returned digest. Define HASH_STREAM_TIMEOUT_EN for the digest watchdog.
module hash_msg_streamer #(
    parameter int unsigned LEN_W       = 64,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             in_start,
    input  logic [31:0]      in_word,
    input  logic [2:0]       in_nbytes,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             h_start,
    output logic [7:0]       h_byte,
    output logic             h_byte_valid,
    input  logic             h_byte_ready,
    output logic             h_end,
    input  logic             h_digest_valid,
    input  logic [31:0]      h_digest,
    output logic             dig_valid,
    output logic [31:0]      dig_out,
    output logic             dig_err,
    input  logic             dig_ready,
    output logic [LEN_W-1:0] msg_len,
    output logic             busy
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_SEND,
        S_END,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] word_r;
    logic [2:0]  nb_r;
    logic [1:0]  idx_r;
    logic        last_r;
    logic [2:0]  in_nb;
    logic        last_byte;

    // Non-final words always carry four bytes; oversize counts saturate at four.
    assign in_nb     = !in_last ? 3'd4 : ((in_nbytes > 3'd4) ? 3'd4 : in_nbytes);
    assign last_byte = ({1'b0, idx_r} == (nb_r - 3'd1));

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

`ifdef HASH_STREAM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] wait_cnt;
`else
    assign dig_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            word_r       <= '0;
            nb_r         <= '0;
            idx_r        <= '0;
            last_r       <= 1'b0;
            in_ready     <= 1'b0;
            h_start      <= 1'b0;
            h_byte       <= '0;
            h_byte_valid <= 1'b0;
            h_end        <= 1'b0;
            dig_valid    <= 1'b0;
            dig_out      <= '0;
            msg_len      <= '0;
            busy         <= 1'b0;
`ifdef HASH_STREAM_TIMEOUT_EN
            dig_err      <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            h_start <= 1'b0;
            h_end   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_start) begin
                        state   <= S_START;
                        h_start <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    state    <= S_LOAD;
                    msg_len  <= '0;
                    in_ready <= 1'b1;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        word_r   <= in_word;
                        nb_r     <= in_nb;
                        last_r   <= in_last;
                        idx_r    <= '0;
                        in_ready <= 1'b0;
                        // nb=0 is only reachable on a last word, so it goes straight to END.
                        if (in_nb != 3'd0) begin
                            state        <= S_SEND;
                            h_byte_valid <= 1'b1;
                            h_byte       <= in_word[7:0];
                        end else begin
                            state <= S_END;
                            h_end <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (h_byte_ready) begin
                        msg_len <= msg_len + LEN_W'(1);
                        idx_r   <= idx_r + 2'd1;
                        if (last_byte) begin
                            h_byte_valid <= 1'b0;
                            if (last_r) begin
                                state <= S_END;
                                h_end <= 1'b1;
                            end else begin
                                state    <= S_LOAD;
                                in_ready <= 1'b1;
                            end
                        end else begin
                            h_byte <= sel_byte(word_r, idx_r + 2'd1);
                        end
                    end
                end
                S_END: begin
                    state <= S_WAIT;
`ifdef HASH_STREAM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (h_digest_valid) begin
                        state     <= S_DONE;
                        dig_out   <= h_digest;
                        dig_valid <= 1'b1;
`ifdef HASH_STREAM_TIMEOUT_EN
                        dig_err   <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state     <= S_DONE;
                        dig_out   <= '0;
                        dig_err   <= 1'b1;
                        dig_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    if (dig_ready) begin
                        state     <= S_IDLE;
                        dig_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
